// File: rtl/lpm_pkg.sv
// Shared types and helpers for the lpm_mul_add_seq block.
package lpm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } mul_state_t;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 0;
      while ((64'd1 << w) < 64'(value)) begin
         w = w + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/lpm_mul_add_seq_if.sv
// Operand/result handshake bundle for lpm_mul_add_seq.
interface lpm_mul_add_seq_if #(
   parameter int WIDTHQ = 32,
   parameter int WIDTHD = 16
);

   logic                     i_valid;
   logic                     o_ready;
   logic [WIDTHQ-1:0]        i_quotient;
   logic [WIDTHD-1:0]        i_denom;
   logic [WIDTHD-1:0]        i_remain;
   logic                     o_valid;
   logic                     i_ready;
   logic [WIDTHQ+WIDTHD-1:0] o_numer;
   logic                     o_consistent;

   modport master (
      output i_valid, i_quotient, i_denom, i_remain, i_ready,
      input  o_ready, o_valid, o_numer, o_consistent
   );

   modport slave (
      input  i_valid, i_quotient, i_denom, i_remain, i_ready,
      output o_ready, o_valid, o_numer, o_consistent
   );

endinterface

// File: rtl/lpm_mul_add_seq.sv
// Sequential shift-add reconstruction numer = quotient*denom + remain,
// one multiplier bit per enabled clock, plus a remainder legality flag.
module lpm_mul_add_seq
   import lpm_pkg::*;
#(
   parameter int WIDTHQ = 32,
   parameter int WIDTHD = 16,
   parameter int SIGNED = 0
) (
   input  logic                 i_clock,
   input  logic                 i_aclr,
   input  logic                 i_clken,
   lpm_mul_add_seq_if.slave     bus
);

   localparam int P  = WIDTHQ + WIDTHD;
   localparam int CW = clog2(WIDTHQ);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTHQ - 1);

   mul_state_t          state_q, state_d;
   logic [P-1:0]        acc_q;
   logic [P-1:0]        mcand_q;
   logic [WIDTHQ-1:0]   mreg_q;
   logic [CW-1:0]       cnt_q;
   logic                consistent_q;

   logic                sign_d, sign_r;
   logic [P-1:0]        denom_ext, remain_ext;
   logic [WIDTHD:0]     denom_mag;
   logic                consistent_d;
   logic                last_bit, sub_en;
   logic [P-1:0]        addend, acc_sum;

   // Operand extension to P bits and remainder legality check on the live inputs.
   always_comb begin
      sign_d     = (SIGNED != 0) && bus.i_denom[WIDTHD-1];
      sign_r     = (SIGNED != 0) && bus.i_remain[WIDTHD-1];
      denom_ext  = {{WIDTHQ{sign_d}}, bus.i_denom};
      remain_ext = {{WIDTHQ{sign_r}}, bus.i_remain};
      // magnitude kept one bit wider so |most-negative denom| is representable
      if (sign_d) begin
         denom_mag = -{1'b1, bus.i_denom};
      end else begin
         denom_mag = {1'b0, bus.i_denom};
      end
      consistent_d = (bus.i_denom != '0) && !sign_r
                     && ({1'b0, bus.i_remain} < denom_mag);
   end

   // Single P-bit adder/subtractor; the signed MSB of the multiplier weighs -2^i.
   always_comb begin
      last_bit = (cnt_q == CNT_LAST);
      sub_en   = (SIGNED != 0) && last_bit;
      addend   = '0;
      if (mreg_q[0]) begin
         addend = sub_en ? ~mcand_q : mcand_q;
      end
      acc_sum = acc_q + addend + P'(mreg_q[0] && sub_en);
   end

   // Next-state logic for the IDLE/RUN/DONE control sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.i_valid) state_d = ST_RUN;
         ST_RUN:  if (last_bit)    state_d = ST_DONE;
         ST_DONE: if (bus.i_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; clock enable freezes the handshake.
   always_ff @(posedge i_clock or posedge i_aclr) begin
      if (i_aclr) begin
         state_q <= ST_IDLE;
      end else if (i_clken) begin
         state_q <= state_d;
      end
   end

   // Datapath: capture operands on accept, then one shift-add step per RUN cycle.
   always_ff @(posedge i_clock or posedge i_aclr) begin
      if (i_aclr) begin
         acc_q        <= '0;
         mcand_q      <= '0;
         mreg_q       <= '0;
         cnt_q        <= '0;
         consistent_q <= 1'b0;
      end else if (i_clken) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.i_valid) begin
                  acc_q        <= remain_ext;
                  mcand_q      <= denom_ext;
                  mreg_q       <= bus.i_quotient;
                  cnt_q        <= '0;
                  consistent_q <= consistent_d;
               end
            end
            ST_RUN: begin
               acc_q   <= acc_sum;
               mcand_q <= mcand_q << 1;
               mreg_q  <= mreg_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Handshake and result outputs decoded from registered state.
   always_comb begin
      bus.o_ready      = (state_q == ST_IDLE);
      bus.o_valid      = (state_q == ST_DONE);
      bus.o_numer      = acc_q;
      bus.o_consistent = consistent_q;
   end

endmodule

// File: tb/tb_lpm_mul_add_seq.sv
// Bench for lpm_mul_add_seq: unsigned and signed instances share stimulus.
module tb_lpm_mul_add_seq;

   localparam int WQ = 8;
   localparam int WD = 4;
   localparam int LAT = 8;

   logic clk = 1'b0;
   logic aclr = 1'b1;
   logic clken = 1'b1;
   logic valid = 1'b0;
   logic rdy = 1'b0;
   logic [WQ-1:0] quotient = '0;
   logic [WD-1:0] denom = '0;
   logic [WD-1:0] remain = '0;

   int checks = 0;
   int errors = 0;

   lpm_mul_add_seq_if #(.WIDTHQ(WQ), .WIDTHD(WD)) bu ();
   lpm_mul_add_seq_if #(.WIDTHQ(WQ), .WIDTHD(WD)) bs ();

   assign bu.i_valid = valid;    assign bs.i_valid = valid;
   assign bu.i_ready = rdy;      assign bs.i_ready = rdy;
   assign bu.i_quotient = quotient; assign bs.i_quotient = quotient;
   assign bu.i_denom = denom;    assign bs.i_denom = denom;
   assign bu.i_remain = remain;  assign bs.i_remain = remain;

   lpm_mul_add_seq #(.WIDTHQ(WQ), .WIDTHD(WD), .SIGNED(0)) u_uns (
      .i_clock(clk), .i_aclr(aclr), .i_clken(clken), .bus(bu));
   lpm_mul_add_seq #(.WIDTHQ(WQ), .WIDTHD(WD), .SIGNED(1)) u_sgn (
      .i_clock(clk), .i_aclr(aclr), .i_clken(clken), .bus(bs));

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [WQ-1:0] q;
      logic [WD-1:0] d;
      logic [WD-1:0] r;
      logic [11:0]   nu;
      logic          cu;
      logic [11:0]   ns;
      logic          cs;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain arithmetic on the operand values, truncated to P bits.
   function automatic logic [11:0] model_numer(input bit sgn, input logic [WQ-1:0] q,
                                                input logic [WD-1:0] d, input logic [WD-1:0] r);
      longint v;
      if (sgn) v = longint'($signed(q)) * longint'($signed(d)) + longint'($signed(r));
      else     v = longint'(q) * longint'(d) + longint'(r);
      return v[11:0];
   endfunction

   function automatic logic model_cons(input bit sgn, input logic [WD-1:0] d, input logic [WD-1:0] r);
      int sd, sr, mag;
      if (sgn) begin sd = int'($signed(d)); sr = int'($signed(r)); end
      else     begin sd = int'(d);          sr = int'(r);          end
      mag = (sd < 0) ? -sd : sd;
      return (sd != 0) && (sr >= 0) && (sr < mag);
   endfunction

   // One full transaction on both instances; call from posedge+#1 with DUTs idle.
   task automatic run_op(input string tag, input logic [WQ-1:0] q, input logic [WD-1:0] d,
                         input logic [WD-1:0] r, input logic [11:0] eu, input logic ecu,
                         input logic [11:0] es, input logic ecs, input int hold, input int gap);
      int lat;
      int exp_lat;
      valid = 1'b1; quotient = q; denom = d; remain = r;
      @(posedge clk); #1;
      check({tag, " busy"}, {bu.o_ready, bs.o_ready}, 0);
      // junk operands with valid still high must be ignored while busy
      quotient = WQ'($urandom); denom = WD'($urandom); remain = WD'($urandom);
      lat = 0;
      while (!bu.o_valid && lat < 40) begin
         if (gap >= 0 && lat == gap) clken = 1'b0;
         if (gap >= 0 && lat == gap + 3) clken = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      clken = 1'b1;
      valid = 1'b0;
      exp_lat = LAT + ((gap >= 0) ? 3 : 0);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " valid"}, {bu.o_valid, bs.o_valid}, 2'b11);
      check({tag, " numer_u"}, bu.o_numer, eu);
      check({tag, " cons_u"}, bu.o_consistent, ecu);
      check({tag, " numer_s"}, bs.o_numer, es);
      check({tag, " cons_s"}, bs.o_consistent, ecs);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, " hold"}, {bu.o_valid, bs.o_valid, bu.o_numer, bs.o_numer}, {2'b11, eu, es});
      end
      rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
      check({tag, " release"}, {bu.o_valid, bs.o_valid, bu.o_ready, bs.o_ready}, 4'b0011);
   endtask

   initial begin
      vecs[0] = '{q: 8'd25,  d: 4'd7,  r: 4'd3, nu: 12'd178,  cu: 1'b1, ns: 12'd178,  cs: 1'b1};
      vecs[1] = '{q: 8'hFD,  d: 4'd5,  r: 4'd2, nu: 12'h4F3,  cu: 1'b1, ns: 12'hFF3,  cs: 1'b1};
      vecs[2] = '{q: 8'h80,  d: 4'h8,  r: 4'd0, nu: 12'd1024, cu: 1'b1, ns: 12'd1024, cs: 1'b1};
      vecs[3] = '{q: 8'h10,  d: 4'd0,  r: 4'd0, nu: 12'd0,    cu: 1'b0, ns: 12'd0,    cs: 1'b0};
      vecs[4] = '{q: 8'd10,  d: 4'd7,  r: 4'd9, nu: 12'd79,   cu: 1'b0, ns: 12'h03F,  cs: 1'b0};
      vecs[5] = '{q: 8'hFF,  d: 4'hF,  r: 4'hF, nu: 12'hF00,  cu: 1'b0, ns: 12'h000,  cs: 1'b0};
      vecs[6] = '{q: 8'h7F,  d: 4'h8,  r: 4'd7, nu: 12'd1023, cu: 1'b1, ns: 12'hC0F,  cs: 1'b1};

      // reset values while aclr is held
      repeat (2) @(posedge clk);
      #1;
      check("reset", {bu.o_ready, bu.o_valid, bu.o_consistent, bs.o_ready, bs.o_valid, bs.o_consistent},
            6'b100100);
      check("reset numer", {bu.o_numer, bs.o_numer}, 24'd0);
      aclr = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].d, vecs[i].r,
                vecs[i].nu, vecs[i].cu, vecs[i].ns, vecs[i].cs, 0, -1);
      end

      // backpressure for 5 cycles, then a clock-enable gap of 3 mid-run
      run_op("backpressure", 8'd25, 4'd7, 4'd3, 12'd178, 1'b1, 12'd178, 1'b1, 5, -1);
      run_op("clken_gap", 8'hFD, 4'd5, 4'd2, 12'h4F3, 1'b1, 12'hFF3, 1'b1, 0, 3);

      // asynchronous clear at cnt=4 mid-run
      valid = 1'b1; quotient = 8'hFF; denom = 4'd7; remain = 4'd3;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 aclr = 1'b1;
      #1;
      check("aclr flags", {bu.o_ready, bu.o_valid, bu.o_consistent, bs.o_ready, bs.o_valid, bs.o_consistent},
            6'b100100);
      check("aclr numer", {bu.o_numer, bs.o_numer}, 24'd0);
      #1 aclr = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("aclr op lost", {bu.o_valid, bs.o_valid, bu.o_ready, bs.o_ready}, 4'b0011);
      run_op("after_aclr", 8'd1, 4'd1, 4'd0, 12'd1, 1'b1, 12'd1, 1'b1, 0, -1);

      // randomized traffic against the arithmetic model
      for (int n = 0; n < 2000; n++) begin
         logic [WQ-1:0] q;
         logic [WD-1:0] d, r;
         q = WQ'($urandom);
         d = WD'($urandom);
         r = WD'($urandom);
         run_op("rand", q, d, r, model_numer(1'b0, q, d, r), model_cons(1'b0, d, r),
                model_numer(1'b1, q, d, r), model_cons(1'b1, d, r),
                int'($urandom_range(0, 2)), (($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : -1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
